// File: rtl/spi_shifter.sv
// SPI mode-0 slave byte shifter: MOSI bytes in with a valid pulse, buffered bytes out on MISO.
// Define SPI_SHIFTER_SYNC_EN for 2-flop input synchronisers (default: single input register).
module spi_shifter #(
  parameter int unsigned   DW   = 8,
  parameter logic [DW-1:0] FILL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sck,
  input  logic          ssn,
  input  logic          mosi,
  output logic          miso,
  output logic [DW-1:0] rx_dat,
  output logic          rx_vld,
  input  logic [DW-1:0] tx_dat,
  input  logic          tx_vld,
  output logic          tx_rdy,
  output logic          tx_overrun,
  output logic          busy,
  output logic          start,
  output logic          tx_byte_done
);

  localparam int unsigned   CW       = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CntLast  = CW'(DW - 1);
  // Pin vector order is {sck, ssn, mosi}; idle is sck=0, ssn=1, mosi=0.
  localparam logic [2:0]    PinIdle  = 3'b010;

  logic [2:0] pins_s;
  logic [2:0] pins_q;

`ifdef SPI_SHIFTER_SYNC_EN
  logic [2:0] meta_q;
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= PinIdle;
      sync_q <= PinIdle;
    end else begin
      meta_q <= {sck, ssn, mosi};
      sync_q <= meta_q;
    end
  end
`else
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= PinIdle;
    end else begin
      sync_q <= {sck, ssn, mosi};
    end
  end
`endif

  assign pins_s = sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pins_q <= PinIdle;
    end else begin
      pins_q <= pins_s;
    end
  end

  logic sck_s, ssn_s, mosi_s;
  logic sck_rise, sck_fall, ssn_fall;

  assign sck_s    = pins_s[2];
  assign ssn_s    = pins_s[1];
  assign mosi_s   = pins_s[0];
  assign sck_rise = sck_s & ~pins_q[2];
  assign sck_fall = ~sck_s & pins_q[2];
  assign ssn_fall = ~ssn_s & pins_q[1];

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rx_sh_q, rx_sh_d;
  logic [DW-1:0] rx_dat_q, rx_dat_d;
  logic          rx_vld_q, rx_vld_d;
  logic          done_q, done_d;
  logic [DW-1:0] tx_sh_q, tx_sh_d;
  logic          from_buf_q, from_buf_d;
  logic [DW-1:0] buf_q, buf_d;
  logic          full_q, full_d;
  logic          ovr_q, ovr_d;
  logic          start_q;
  logic          load, take;

  always_comb begin
    cnt_d      = cnt_q;
    rx_sh_d    = rx_sh_q;
    rx_dat_d   = rx_dat_q;
    rx_vld_d   = 1'b0;
    done_d     = 1'b0;
    tx_sh_d    = tx_sh_q;
    from_buf_d = from_buf_q;
    buf_d      = buf_q;
    full_d     = full_q;
    ovr_d      = 1'b0;
    load       = 1'b0;
    take       = 1'b0;

    if (ssn_s) begin
      cnt_d   = '0;
      rx_sh_d = '0;
    end else if (ssn_fall) begin
      cnt_d   = '0;
      rx_sh_d = '0;
      load    = 1'b1;
    end else if (sck_rise) begin
      rx_sh_d = {rx_sh_q[DW-2:0], mosi_s};
      if (cnt_q == CntLast) begin
        cnt_d    = '0;
        rx_dat_d = rx_sh_d;
        rx_vld_d = 1'b1;
        done_d   = from_buf_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (sck_fall) begin
      if (cnt_q != '0) begin
        tx_sh_d = {tx_sh_q[DW-2:0], 1'b0};
      end else begin
        load = 1'b1;
      end
    end

    if (load) begin
      from_buf_d = full_q;
      tx_sh_d    = full_q ? buf_q : FILL;
    end
    take = load & full_q;

    // A load in the same cycle frees the slot, so a concurrent write is kept.
    if (tx_vld) begin
      if (!full_q || take) begin
        buf_d  = tx_dat;
        full_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (take) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      rx_sh_q    <= '0;
      rx_dat_q   <= '0;
      rx_vld_q   <= 1'b0;
      done_q     <= 1'b0;
      tx_sh_q    <= FILL;
      from_buf_q <= 1'b0;
      buf_q      <= '0;
      full_q     <= 1'b0;
      ovr_q      <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_dat_q   <= rx_dat_d;
      rx_vld_q   <= rx_vld_d;
      done_q     <= done_d;
      tx_sh_q    <= tx_sh_d;
      from_buf_q <= from_buf_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
      ovr_q      <= ovr_d;
      start_q    <= ssn_fall;
    end
  end

  assign miso         = tx_sh_q[DW-1];
  assign rx_dat       = rx_dat_q;
  assign rx_vld       = rx_vld_q;
  assign tx_rdy       = ~full_q;
  assign tx_overrun   = ovr_q;
  assign busy         = ~ssn_s;
  assign start        = start_q;
  assign tx_byte_done = done_q;

endmodule

// File: tb/tb_spi_shifter.sv
// Scoreboard bench for spi_shifter: a bit-banged SPI master drives the pins while a monitor
// checks every rx_vld against queued expected bytes.
module tb_spi_shifter;

  localparam int HALF = 8;  // sck half period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       sck, ssn, mosi, miso;
  logic [7:0] rx_dat, tx_dat;
  logic       rx_vld, tx_vld, tx_rdy, tx_overrun, busy, start, tx_byte_done;

  spi_shifter #(
    .DW   (8),
    .FILL (8'h00)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sck          (sck),
    .ssn          (ssn),
    .mosi         (mosi),
    .miso         (miso),
    .rx_dat       (rx_dat),
    .rx_vld       (rx_vld),
    .tx_dat       (tx_dat),
    .tx_vld       (tx_vld),
    .tx_rdy       (tx_rdy),
    .tx_overrun   (tx_overrun),
    .busy         (busy),
    .start        (start),
    .tx_byte_done (tx_byte_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] dat;
    logic       done;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  int         start_cnt = 0;
  int         ovr_cnt = 0;
  logic       done = 1'b0;
  logic [7:0] got;
  logic [7:0] mo_bytes [5] = '{8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE};
  logic [7:0] mi_exp   [5] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      wait_clk(HALF);
      mi = {mi[6:0], miso};
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
    end
  endtask

  initial begin
    rst    = 1'b0;
    sck    = 1'b0;
    ssn    = 1'b1;
    mosi   = 1'b0;
    tx_vld = 1'b0;
    tx_dat = '0;
    fork
      begin : monitor
        while (!done) begin
          @(negedge clk);
          if (rx_vld) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rx_unexpected: got rx_vld with rx_dat %0h expected no rx_vld", rx_dat);
            end else begin
              e = exp_q.pop_front();
              chk("rx_dat", {24'd0, rx_dat}, {24'd0, e.dat});
              chk("tx_byte_done", {31'd0, tx_byte_done}, {31'd0, e.done});
            end
          end else if (tx_byte_done) begin
            checks++;
            errors++;
            $display("FAIL tx_byte_done_stray: got 1 expected 0 (no rx_vld)");
          end
          if (start) start_cnt++;
          if (tx_overrun) ovr_cnt++;
        end
      end
      begin : stimulus
        #100 rst = 1'b1;
        wait_clk(2);
        chk("rst_rx_dat", {24'd0, rx_dat}, 0);
        chk("rst_rx_vld", {31'd0, rx_vld}, 0);
        chk("rst_tx_rdy", {31'd0, tx_rdy}, 1);
        chk("rst_tx_overrun", {31'd0, tx_overrun}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_start", {31'd0, start}, 0);
        chk("rst_tx_byte_done", {31'd0, tx_byte_done}, 0);
        chk("rst_miso", {31'd0, miso}, 0);

        // Five-byte transaction with loopback replies 1..4 written after each rx_vld.
        exp_q.push_back('{8'hAA, 1'b0});
        exp_q.push_back('{8'hAB, 1'b1});
        exp_q.push_back('{8'hAC, 1'b1});
        exp_q.push_back('{8'hAD, 1'b1});
        exp_q.push_back('{8'hAE, 1'b1});
        ssn = 1'b0;
        wait_clk(HALF);
        chk("busy_active", {31'd0, busy}, 1);
        fork
          begin
            for (int b = 0; b < 5; b++) begin
              spi_xfer(mo_bytes[b], 8, got);
              chk($sformatf("loop_miso_%0d", b), {24'd0, got}, {24'd0, mi_exp[b]});
            end
          end
          begin
            for (int k = 1; k <= 4; k++) begin
              int t;
              t = 0;
              @(posedge clk);
              #1;
              while (!rx_vld && t < 400) begin
                @(posedge clk);
                #1;
                t++;
              end
              if (!rx_vld) begin
                checks++;
                errors++;
                $display("FAIL loop_rx_wait: got timeout expected rx_vld %0d", k);
              end else begin
                tx_dat = 8'(k);
                tx_vld = 1'b1;
                @(posedge clk);
                #1;
                tx_vld = 1'b0;
              end
            end
          end
        join
        wait_clk(HALF);
        ssn = 1'b1;
        wait_clk(2 * HALF);
        chk("start_count_1", start_cnt, 1);
        chk("rx_pending_1", exp_q.size(), 0);
        chk("busy_idle", {31'd0, busy}, 0);
        chk("tx_rdy_after_loop", {31'd0, tx_rdy}, 1);

        // Second write with the buffer full must be dropped.
        tx_dat = 8'hC3;
        tx_vld = 1'b1;
        wait_clk(1);
        tx_vld = 1'b0;
        wait_clk(1);
        chk("tx_rdy_full", {31'd0, tx_rdy}, 0);
        tx_dat = 8'h22;
        tx_vld = 1'b1;
        wait_clk(1);
        tx_vld = 1'b0;
        wait_clk(3);
        chk("overrun_count", ovr_cnt, 1);
        chk("tx_rdy_still_full", {31'd0, tx_rdy}, 0);

        // Abort after 4 bits; MISO must show the kept byte 0xC3.
        ssn = 1'b0;
        wait_clk(HALF);
        spi_xfer(8'hF0, 4, got);
        chk("partial_miso", {28'd0, got[3:0]}, 32'hC);
        wait_clk(HALF);
        ssn = 1'b1;
        wait_clk(2 * HALF);
        chk("tx_rdy_after_start_load", {31'd0, tx_rdy}, 1);

        // Full byte with an empty buffer shifts FILL.
        exp_q.push_back('{8'h5A, 1'b0});
        ssn = 1'b0;
        wait_clk(HALF);
        spi_xfer(8'h5A, 8, got);
        chk("fill_miso", {24'd0, got}, 0);
        wait_clk(HALF);
        ssn = 1'b1;
        wait_clk(2 * HALF);
        chk("start_count_total", start_cnt, 3);
        chk("rx_pending_2", exp_q.size(), 0);
        chk("rx_dat_held", {24'd0, rx_dat}, 32'h5A);
        done = 1'b1;
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
